reset_sequencer: RTL
====================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 LOCK_STABLE = 1024; cycles pll_locked must stay high before any downstream reset is released.
REQ-002 DONE_TIMEOUT = 1_000_000; cycles allowed for each init-done acknowledge.
REQ-003 PLL_RST_CYCLES = 16; width in cycles of the pll_areset pulse.
REQ-004 MAX_RETRY = 3; number of full restart attempts before the block enters FAULT.
REQ-005 clk  input  1  system clock, 50 MHz; all logic on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset; internally synchronized on deassertion.
REQ-007 pll_locked  input  1  PLL lock indicator, asynchronous; double-flopped before use.
REQ-008 sdram_init_done  input  1  SDRAM controller init acknowledge, level, synchronous to clk.
REQ-009 cam_cfg_done  input  1  camera SCCB configuration acknowledge, level, synchronous to clk.
REQ-010 pll_areset  output  1  active-high PLL reset request.
REQ-011 sdram_rst_n  output  1  active-low reset to the SDRAM controller.
REQ-012 cam_rst_n  output  1  active-low reset to the camera configuration/capture path.
REQ-013 vga_rst_n  output  1  active-low reset to the VGA output path.
REQ-014 running  output  1  high only in state RUN.
REQ-015 fault  output  1  high only in state FAULT.
REQ-016 retry_cnt  output  2  number of restarts performed since reset.

Function
REQ-017 States: PLL_RST, WAIT_LOCK, STABLE, REL_SDRAM, WAIT_SDRAM, REL_CAM, WAIT_CAM, REL_VGA, RUN, FAULT.
REQ-018 PLL_RST: pll_areset=1 for exactly PLL_RST_CYCLES cycles, then go to WAIT_LOCK.
REQ-019 WAIT_LOCK: wait with no timeout until synced lock=1, then go to STABLE with the counter cleared.
REQ-020 STABLE: count consecutive locked cycles; on reaching LOCK_STABLE go to REL_SDRAM; lock=0 returns to WAIT_LOCK.
REQ-021 REL_SDRAM: sdram_rst_n<=1 (registered, takes effect next cycle); go to WAIT_SDRAM with the timeout counter cleared.
REQ-022 WAIT_SDRAM: sdram_init_done=1 moves to REL_CAM; DONE_TIMEOUT cycles without it is a timeout.
REQ-023 REL_CAM and WAIT_CAM: same rules as REQ-021 and REQ-022, using cam_rst_n and cam_cfg_done.
REQ-024 REL_VGA: vga_rst_n<=1, then go to RUN one cycle later.
REQ-025 Release order is strictly sdram, then cam, then vga; no downstream reset is ever released while an earlier one is asserted.
REQ-026 Lock loss (synced lock=0) in REL_SDRAM through RUN: assert all three resets in the same cycle the loss is seen, increment retry_cnt, go to PLL_RST.
REQ-027 Timeout: assert all three resets, increment retry_cnt, go to PLL_RST.
REQ-028 When a restart would make retry_cnt exceed MAX_RETRY, go to FAULT instead; retry_cnt saturates at 3.
REQ-029 FAULT: all resets asserted, pll_areset=0; only rst_n exits FAULT.
REQ-030 Lock loss and timeout in the same cycle count as one restart.
REQ-031 sdram_init_done and cam_cfg_done dropping while in RUN are ignored.
REQ-032 All outputs are registered; no combinational path from any input to any output.

Reset
REQ-033 While rst_n=0: pll_areset=1, all downstream resets=0, running=0, fault=0, retry_cnt=0, state=PLL_RST, all counters=0.
REQ-034 After rst_n rises, 2 synchronizer cycles pass before PLL_RST begins counting.
REQ-035 rst_n asserted mid-operation: all outputs return to the REQ-033 values asynchronously.

Structure
REQ-036 State encoding and default parameter constants live in a shared package, reset_seq_pkg.
REQ-037 The rst_n and pll_locked double-flop synchronizers are one sub-module, sync_2ff, instantiated twice.
REQ-038 A single 20-bit counter is shared by PLL_RST, STABLE and the timeout waits.

Verification (LOCK_STABLE=8, DONE_TIMEOUT=50, PLL_RST_CYCLES=4)
REQ-039 Clean boot: lock at cycle 20, sdram_done 10 cycles after release, cam_done 10 cycles after release -> resets release in order sdram, cam, vga; running=1; retry_cnt=0.
REQ-040 Lock glitch in STABLE after 5 cycles -> return to WAIT_LOCK; sdram_rst_n stays 0; no retry counted.
REQ-041 Lock loss in RUN -> all resets=0 on the next edge, pll_areset high for 4 cycles, retry_cnt=1, full re-sequence follows.
REQ-042 cam_cfg_done never asserted -> three restarts 50 cycles apart, then fault=1, retry_cnt=3, pll_areset=0.
REQ-043 rst_n pulsed low while in WAIT_CAM -> outputs immediately equal reset values; the boot sequence restarts cleanly.
REQ-044 Assertion runs throughout every test: cam_rst_n=1 implies sdram_rst_n=1, and vga_rst_n=1 implies cam_rst_n=1.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: state encoding, default timing constants and state-to-output decode
package reset_seq_pkg;

   localparam int DEF_LOCK_STABLE    = 1024;
   localparam int DEF_DONE_TIMEOUT   = 1_000_000;
   localparam int DEF_PLL_RST_CYCLES = 16;
   localparam int DEF_MAX_RETRY      = 3;
   localparam int CNT_W              = 20;

   typedef enum logic [3:0] {
      PLL_RST, WAIT_LOCK, STABLE, REL_SDRAM, WAIT_SDRAM,
      REL_CAM, WAIT_CAM, REL_VGA, RUN, FAULT
   } state_t;

   typedef struct packed {
      logic pll_areset;
      logic sdram_rst_n;
      logic cam_rst_n;
      logic vga_rst_n;
      logic running;
      logic fault;
   } outs_t;

   function automatic outs_t decode(state_t s);
      return '{pll_areset:  s == PLL_RST,
               sdram_rst_n: s >= WAIT_SDRAM && s <= RUN,
               cam_rst_n:   s >= WAIT_CAM && s <= RUN,
               vga_rst_n:   s == RUN,
               running:     s == RUN,
               fault:       s == FAULT};
   endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if: lock/acknowledge inputs and reset/status outputs of the sequencer
interface reset_sequencer_if;

   logic       pll_locked;
   logic       sdram_init_done;
   logic       cam_cfg_done;
   logic       pll_areset;
   logic       sdram_rst_n;
   logic       cam_rst_n;
   logic       vga_rst_n;
   logic       running;
   logic       fault;
   logic [1:0] retry_cnt;

   modport master (
      input  pll_locked, sdram_init_done, cam_cfg_done,
      output pll_areset, sdram_rst_n, cam_rst_n, vga_rst_n, running, fault, retry_cnt
   );

   modport slave (
      output pll_locked, sdram_init_done, cam_cfg_done,
      input  pll_areset, sdram_rst_n, cam_rst_n, vga_rst_n, running, fault, retry_cnt
   );

endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer with asynchronous active-low clear
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;

   // clear both stages on reset, otherwise shift the input through two flops
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) {q_o, meta_q} <= 2'b00;
      else        {q_o, meta_q} <= {meta_q, d_i};

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: brings up PLL, then releases SDRAM, camera and VGA resets in order, with retry and fault
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int LOCK_STABLE    = DEF_LOCK_STABLE,
   parameter int DONE_TIMEOUT   = DEF_DONE_TIMEOUT,
   parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
   parameter int MAX_RETRY      = DEF_MAX_RETRY
) (
   input  logic              clk,
   input  logic              rst_n,
   reset_sequencer_if.master bus
);

   logic             rst_sync_n, lock_s, restart;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       retry_q, retry_d;
   outs_t            outs_q;

   sync_2ff u_rst_sync  (.clk(clk), .rst_n(rst_n), .d_i(1'b1),           .q_o(rst_sync_n));
   sync_2ff u_lock_sync (.clk(clk), .rst_n(rst_n), .d_i(bus.pll_locked), .q_o(lock_s));

   // next state, shared counter and retry bookkeeping; lock loss and timeout fold into one restart
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
      retry_d = retry_q;
      restart = 1'b0;
      case (state_q)
         PLL_RST:    if (cnt_q == CNT_W'(PLL_RST_CYCLES - 1)) state_d = WAIT_LOCK;
         WAIT_LOCK:  if (lock_s) begin
                        state_d = STABLE;
                        cnt_d   = '0;
                     end
         STABLE:     if (!lock_s) state_d = WAIT_LOCK;
                     else if (cnt_q == CNT_W'(LOCK_STABLE - 1)) state_d = REL_SDRAM;
         REL_SDRAM:  begin
                        state_d = WAIT_SDRAM;
                        cnt_d   = '0;
                     end
         WAIT_SDRAM: if (bus.sdram_init_done) state_d = REL_CAM;
                     else if (cnt_q == CNT_W'(DONE_TIMEOUT - 1)) restart = 1'b1;
         REL_CAM:    begin
                        state_d = WAIT_CAM;
                        cnt_d   = '0;
                     end
         WAIT_CAM:   if (bus.cam_cfg_done) state_d = REL_VGA;
                     else if (cnt_q == CNT_W'(DONE_TIMEOUT - 1)) restart = 1'b1;
         REL_VGA:    state_d = RUN;
         default:    ;
      endcase
      if (!lock_s && state_q >= REL_SDRAM && state_q <= RUN) restart = 1'b1;
      if (restart) begin
         cnt_d   = '0;
         state_d = (retry_q == 2'(MAX_RETRY)) ? FAULT : PLL_RST;
         retry_d = (retry_q == 2'(MAX_RETRY)) ? retry_q : retry_q + 2'd1;
      end
   end

   // state, counter, retry and output registers; held at reset values until the reset synchronizer releases
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= PLL_RST;
         cnt_q   <= '0;
         retry_q <= '0;
         outs_q  <= decode(PLL_RST);
      end else if (rst_sync_n) begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         retry_q <= retry_d;
         outs_q  <= decode(state_d);
      end

   assign bus.pll_areset  = outs_q.pll_areset;
   assign bus.sdram_rst_n = outs_q.sdram_rst_n;
   assign bus.cam_rst_n   = outs_q.cam_rst_n;
   assign bus.vga_rst_n   = outs_q.vga_rst_n;
   assign bus.running     = outs_q.running;
   assign bus.fault       = outs_q.fault;
   assign bus.retry_cnt   = retry_q;

endmodule
